// File: rtl/serial_pattern_tx.sv
// Serial word transmitter: shifts a WIDTH-bit word out MSB-first on x, counts
// 0->1 transitions for scoreboarding, and inserts an idle gap between words.
//
// state | meaning
// IDLE  | ready=1, waiting for load
// SHIFT | emitting word bits on x, x_valid=1
// GAP   | idle gap after a word, x=0, ready=0
module serial_pattern_tx #(
    parameter int WIDTH      = 14,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done,
    output logic [CNT_W-1:0] cnt01
);

    localparam int CTR_MAX = (WIDTH > GAP_CYCLES) ? WIDTH : GAP_CYCLES;
    localparam int CTR_W   = $clog2(CTR_MAX + 1);
    localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(WIDTH - 1);
    localparam logic [CTR_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CTR_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CTR_W-1:0] bit_ctr;
    logic             accept;
    logic             last_bit;

    assign ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // bit_ctr is a down-counter reused for the word length and then the gap length
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_ctr == '0) begin
                    last_bit  = 1'b1;
                    state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (bit_ctr == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x       <= 1'b0;
            x_valid <= 1'b0;
            done    <= 1'b0;
            cnt01   <= '0;
            shreg   <= '0;
            bit_ctr <= '0;
        end else begin
            done <= last_bit;
            if (accept) begin
                x       <= data[WIDTH-1];
                x_valid <= 1'b1;
                shreg   <= {data[WIDTH-2:0], 1'b0};
                bit_ctr <= LAST_IDX;
                cnt01   <= '0;
            end else if (last_bit) begin
                x       <= 1'b0;
                x_valid <= 1'b0;
                bit_ctr <= GAP_LAST;
            end else if (state == SHIFT) begin
                x       <= shreg[WIDTH-1];
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                bit_ctr <= bit_ctr - 1'b1;
                // x still holds the previous bit, so this detects a 0->1 pair
                if (!x && shreg[WIDTH-1] && (cnt01 != '1))
                    cnt01 <= cnt01 + 1'b1;
            end else if (state == GAP) begin
                bit_ctr <= bit_ctr - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: two instances (gap 2 / 4-bit count, gap 0 / 2-bit
// count) checked every cycle against a word-timeline model.
module tb_serial_pattern_tx;

    localparam int W = 14;
    localparam int GAP[2]  = '{2, 0};
    localparam int CMAX[2] = '{15, 3};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [W-1:0]  data = '0;
    logic          ready_o[2], x_o[2], xv_o[2], done_o[2];
    logic [3:0]    cnt_a;
    logic [1:0]    cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(W), .GAP_CYCLES(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .load(load), .data(data),
        .ready(ready_o[0]), .x(x_o[0]), .x_valid(xv_o[0]), .done(done_o[0]), .cnt01(cnt_a));

    serial_pattern_tx #(.WIDTH(W), .GAP_CYCLES(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .load(load), .data(data),
        .ready(ready_o[1]), .x(x_o[1]), .x_valid(xv_o[1]), .done(done_o[1]), .cnt01(cnt_b));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // 0->1 pairs in send order (MSB first), saturating at cmax
    function automatic int pairs(input logic [W-1:0] w, input int cmax);
        int n = 0;
        for (int k = 1; k < W; k++)
            if (w[W-k] == 1'b0 && w[W-1-k] == 1'b1) n++;
        return (n > cmax) ? cmax : n;
    endfunction

    // Model: each instance remembers the edge index of its last accept and the word
    int           ecnt = 0;
    bit           act[2] = '{0, 0};
    int           e[2];
    logic [W-1:0] wd[2];

    always @(posedge clk) begin
        ecnt = ecnt + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) act[i] = 0;
            else if (load && (!act[i] || (ecnt - 1 - e[i]) >= W + GAP[i])) begin
                act[i] = 1;
                e[i]   = ecnt;
                wd[i]  = data;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            int o;
            int ex_xv, ex_x, ex_done, ex_rdy, act_cnt;
            o       = ecnt - e[i];
            ex_xv   = (act[i] && o <= W - 1) ? 1 : 0;
            ex_x    = ex_xv ? int'(wd[i][W-1-o]) : 0;
            ex_done = (act[i] && o == W) ? 1 : 0;
            ex_rdy  = (!act[i] || o >= W + GAP[i]) ? 1 : 0;
            act_cnt = (i == 0) ? int'(cnt_a) : int'(cnt_b);
            chk($sformatf("x[%0d]", i), int'(x_o[i]), ex_x);
            chk($sformatf("x_valid[%0d]", i), int'(xv_o[i]), ex_xv);
            chk($sformatf("done[%0d]", i), int'(done_o[i]), ex_done);
            chk($sformatf("ready[%0d]", i), int'(ready_o[i]), ex_rdy);
            if (!act[i])
                chk($sformatf("cnt01_idle[%0d]", i), act_cnt, 0);
            else if (o >= W)
                chk($sformatf("cnt01[%0d]", i), act_cnt, pairs(wd[i], CMAX[i]));
        end
    end

    task automatic idle(input int n);
        load = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        bit seen;

        chk("pairs_ex2", pairs(14'b00100011101100, 15), 3);
        chk("pairs_ones", pairs(14'h3FFF, 15), 0);
        chk("pairs_alt", pairs(14'b01010101010101, 15), 7);
        chk("pairs_alt_sat", pairs(14'b01010101010101, 3), 3);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // directed word with literal latency and count
        data = 14'b00100011101100;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        k = 1;
        seen = 0;
        while (k < 30 && !seen) begin
            if (done_o[0]) seen = 1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk("done_seen", int'(seen), 1);
        chk("done_latency", k, 15);
        chk("cnt01_ex2", int'(cnt_a), 3);
        idle(8);

        // back-to-back with load held high
        data = 14'h3FFF;
        load = 1'b1;
        @(negedge clk);
        data = 14'h0000;
        repeat (40) @(negedge clk);
        idle(20);

        // saturating count
        data = 14'b01010101010101;
        load = 1'b1;
        @(negedge clk);
        idle(20);

        // inputs wiggled mid-word must be ignored
        data = W'($urandom);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        for (int c = 3; c <= 10; c++) begin
            load = 1'(c % 2);
            data = W'($urandom);
            @(negedge clk);
        end
        idle(12);

        // reset mid-word
        data = 14'b10110011100101;
        load = 1'b1;
        @(negedge clk);
        idle(6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(20);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 2) == 0);
            data = W'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
